// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// State encoding plus default timing constants.
package fifo_uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int FIFO_DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  // States in which the line is being timed bit by bit.
  function automatic logic is_timed(input state_t s);
    return (s == START) || (s == DATA) || (s == STOP);
  endfunction

endpackage

// File: rtl/fifo_generic.sv
// Simple synchronous FIFO with registered read data.
// rd_data is valid the cycle after a pop.
module fifo_generic #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  // Pointer and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wptr <= wptr + (AW+1)'(1);
      if (do_rd) begin
        rptr    <= rptr + (AW+1)'(1);
        rd_data <= mem[rptr[AW-1:0]];
      end
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter.
// Pulses bit_done on the last cycle of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_done = !clear && (cnt == LAST);

  // Count 0..CLKS_PER_BIT-1, held at zero while cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a FIFO.
// One pop per frame; 8N1-style framing, LSB first.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = FIFO_DATA_WIDTH_DEFAULT,
  parameter int CLKS_PER_BIT    = CLKS_PER_BIT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       empty,
  output logic                       read,
  input  logic [FIFO_DATA_WIDTH-1:0] read_data,
  output logic                       tx,
  output logic                       busy
);

  localparam int BW = $clog2(FIFO_DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FIFO_DATA_WIDTH - 1);

  state_t                     state;
  logic [FIFO_DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]              bit_cnt;
  logic                       bit_done;
  logic                       baud_clear;

  assign baud_clear = !is_timed(state);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  // Frame sequencer with registered line, pop and busy outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      read    <= 1'b0;
      busy    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      read <= 1'b0;
      unique case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (!empty) begin
            state <= READ;
            read  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        READ: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg   <= read_data;
          bit_cnt <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (bit_done) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt == LAST_BIT) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            if (!empty) begin
              state <= READ;
              read  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench: FIFO feeding the UART transmitter.
// Expected line levels come from a queue model.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int FRAME = (DW + 2) * N;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fifo_rst_n;
  logic          wr;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          read;
  logic [DW-1:0] read_data;
  logic          empty;
  logic          tx;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  int nreads = 0;
  logic [DW-1:0] mq[$];

  always #5 clk = ~clk;

  fifo_generic #(.DEPTH(8), .WIDTH(DW)) u_fifo (
    .clk    (clk),
    .rst_n  (fifo_rst_n),
    .wr     (wr),
    .wr_data(wr_data),
    .full   (full),
    .rd     (read),
    .rd_data(read_data),
    .empty  (empty)
  );

  fifo_uart_tx #(.FIFO_DATA_WIDTH(DW), .CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .empty    (empty),
    .read     (read),
    .read_data(read_data),
    .tx       (tx),
    .busy     (busy)
  );

  // Continuous protocol invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (read) nreads++;
      vectors += 3;
      assert (!(read && empty)) else begin
        miscompares++;
        $error("FAIL read_while_empty: observed 1 expected 0");
      end
      assert (!(dut.state == IDLE && tx !== 1'b1)) else begin
        miscompares++;
        $error("FAIL tx_low_in_idle: observed %b expected 1", tx);
      end
      assert (busy === (dut.state != IDLE)) else begin
        miscompares++;
        $error("FAIL busy_vs_state: observed %b expected %b",
               busy, dut.state != IDLE);
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fifo_write(input logic [DW-1:0] d);
    wr = 1'b1;
    wr_data = d;
    if (mq.size() < 8) mq.push_back(d);
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic wait_read(input int budget, output int waited);
    waited = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (read) begin
        waited = i;
        break;
      end
    end
    vectors++;
    assert (waited != 0) else begin
      miscompares++;
      $error("FAIL read_timeout: observed none expected pulse within %0d",
             budget);
    end
  endtask

  // Called with read visible in the current cycle; walks one frame.
  task automatic run_frame(input int inj_j, input logic [DW-1:0] inj_d,
                           input int abort_j);
    logic [DW-1:0] exp;
    logic eb;
    logic injected;
    int idx;
    int w;
    exp = mq.pop_front();
    injected = 1'b0;
    for (int j = 1; j <= FRAME + 1; j++) begin
      @(posedge clk); #1;
      if (injected) begin
        wr = 1'b0;
        injected = 1'b0;
      end
      if (j == 1) begin
        eb = 1'b1;
      end else begin
        idx = (j - 2) / N;
        if (idx == 0) eb = 1'b0;
        else if (idx == DW + 1) eb = 1'b1;
        else eb = exp[idx-1];
      end
      chk($sformatf("frame_%h_c%0d", exp, j),
          {5'b0, tx, read, busy}, {5'b0, eb, 1'b0, 1'b1});
      if (j == inj_j) begin
        wr = 1'b1;
        wr_data = inj_d;
        if (mq.size() < 8) mq.push_back(inj_d);
        injected = 1'b1;
      end
      if (j == abort_j) begin
        #2 reset_n = 1'b0;
        #1 chk("abort_now", {5'b0, tx, read, busy}, 8'h04);
        repeat (2) @(posedge clk);
        #1 chk("abort_held", {5'b0, tx, read, busy}, 8'h04);
        @(negedge clk) reset_n = 1'b1;
        return;
      end
    end
    if (mq.size() > 0) begin
      wait_read(5, w);
      chk("b2b_gap", 8'(w), 8'd1);
    end else begin
      @(posedge clk); #1;
      chk("to_idle", {5'b0, tx, read, busy}, 8'h04);
    end
  endtask

  task automatic drain();
    while (mq.size() > 0) run_frame(0, '0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int r0;
    int n;
    wr = 1'b0;
    wr_data = '0;
    reset_n = 1'b1;
    fifo_rst_n = 1'b1;
    #1;
    reset_n = 1'b0;
    fifo_rst_n = 1'b0;
    #1;
    chk("reset_state", {5'b0, tx, read, busy}, 8'h04);
    repeat (2) @(negedge clk);
    fifo_rst_n = 1'b1;

    // Word queued while held in reset; release pops on first edge.
    fifo_write(8'h5A);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("held_reset", {4'b0, tx, read, busy, empty}, 8'h08);
    end
    @(negedge clk) reset_n = 1'b1;
    wait_read(5, w);
    chk("first_read_latency", 8'(w), 8'd1);
    drain();

    // Single word into an idle, empty FIFO.
    r0 = nreads;
    fifo_write(8'hA5);
    wait_read(10, w);
    drain();
    chk("a5_reads", 8'(nreads - r0), 8'd1);

    // Ten writes while held: only eight fit, eight frames follow.
    @(negedge clk) reset_n = 1'b0;
    for (int k = 0; k < 10; k++) fifo_write(8'(k));
    chk("model_depth", 8'(mq.size()), 8'd8);
    chk("fifo_full", {7'b0, full}, 8'd1);
    r0 = nreads;
    @(negedge clk) reset_n = 1'b1;
    wait_read(5, w);
    drain();
    chk("burst_reads", 8'(nreads - r0), 8'd8);

    // Empty drops and rises during DATA of 8'h10.
    r0 = nreads;
    fifo_write(8'h10);
    wait_read(10, w);
    run_frame(2 + 3 * N, 8'h77, 0);
    drain();
    chk("empty_toggle_reads", 8'(nreads - r0), 8'd2);

    // Reset during bit 3 of 8'hFF; next word sent whole.
    @(negedge clk) reset_n = 1'b0;
    fifo_write(8'hFF);
    fifo_write(8'h3C);
    r0 = nreads;
    @(negedge clk) reset_n = 1'b1;
    wait_read(5, w);
    run_frame(0, '0, 2 + 4 * N + 1);
    wait_read(5, w);
    chk("post_abort_latency", 8'(w), 8'd1);
    drain();
    chk("abort_reads", 8'(nreads - r0), 8'd2);

    // Random bursts loaded under reset.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk) reset_n = 1'b0;
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) fifo_write(8'($urandom_range(0, 255)));
      r0 = nreads;
      @(negedge clk) reset_n = 1'b1;
      wait_read(5, w);
      chk("rand_first_read", 8'(w), 8'd1);
      drain();
      chk("rand_reads", 8'(nreads - r0), 8'((n > 8) ? 8 : n));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
